// File: rtl/secuenciador_prueba_abcd_pkg.sv
// Shared definitions for the ABCD self-test sequencer.
//   estado_t      : sequencer FSM states
//   N_VECT        : number of ABCD codes swept (0..15)
//   EXPECTED_DEF  : packed {F1,F2} truth table of circuito_compuertas,
//                   bits [2i+1:2i] hold code i with F1 as the MSB
package secuenciador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APLICA  = 2'd1,
        MUESTRA = 2'd2,
        DONE    = 2'd3
    } estado_t;

    localparam int          N_VECT       = 16;
    localparam logic [31:0] EXPECTED_DEF = 32'hEEEE_76EC;

endpackage

// File: rtl/secuenciador_prueba_abcd_contador_asentamiento.sv
// Settle-time counter for the ABCD sequencer.
// Counts up from 0 while enabled and stops at SETTLE_CYCLES-1, where tc is
// raised; clr returns it to 0.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (priority over en)
//   en     : count enable
//   tc     : terminal count, high while cnt == SETTLE_CYCLES-1
module contador_asentamiento
    import secuenciador_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [W-1:0]   TC_VAL = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/secuenciador_prueba_abcd.sv
// Built-in self-test sequencer for circuito_compuertas.
// On start, drives ABCD through codes 0..15, holds each for SETTLE_CYCLES,
// samples {f1,f2}, compares against EXPECTED and accumulates an error count.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : sweep request, honoured only in IDLE or DONE
//   abcd           : vector applied to the gate circuit (abcd[3]=A)
//   f1, f2         : gate circuit outputs
//   busy, done     : sweep in progress / sweep finished
//   pass           : done with no mismatches
//   err_count      : mismatches in the current/last sweep (0..16)
//   err_first_idx  : code of the first mismatch
//   sample_valid   : one-cycle pulse after each sample
//   sample_idx, sample_f, sample_err : details of the last sample
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for start after reset
// APLICA  | abcd applied, waiting SETTLE_CYCLES to settle
// MUESTRA | sample {f1,f2} and compare on the closing edge
// DONE    | sweep complete, results held until next start
module secuenciador_prueba_abcd
    import secuenciador_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] EXPECTED      = EXPECTED_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] abcd,
    input  logic       f1,
    input  logic       f2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] err_first_idx,
    output logic       sample_valid,
    output logic [3:0] sample_idx,
    output logic [1:0] sample_f,
    output logic       sample_err
);

    localparam logic [3:0] ULTIMO = 4'(N_VECT - 1);

    estado_t    estado, estado_sig;
    logic [3:0] idx;
    logic       tc;
    logic       arranque;
    logic       desajuste;

    // start is ignored while a sweep is running, including the final MUESTRA
    assign arranque  = start && ((estado == IDLE) || (estado == DONE));
    assign desajuste = ({f1, f2} != EXPECTED[{idx, 1'b0} +: 2]);

    contador_asentamiento #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arranque || (estado == MUESTRA)),
        .en    (estado == APLICA),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE, DONE: if (start) estado_sig = APLICA;
            APLICA:     if (tc) estado_sig = MUESTRA;
            MUESTRA:    estado_sig = (idx == ULTIMO) ? DONE : APLICA;
            default:    estado_sig = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (estado)
            APLICA, MUESTRA: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (err_count == 5'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            err_count     <= '0;
            err_first_idx <= '0;
            sample_valid  <= 1'b0;
            sample_idx    <= '0;
            sample_f      <= '0;
            sample_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (arranque) begin
                idx           <= '0;
                err_count     <= '0;
                err_first_idx <= '0;
            end else if (estado == MUESTRA) begin
                sample_valid <= 1'b1;
                sample_idx   <= idx;
                sample_f     <= {f1, f2};
                sample_err   <= desajuste;
                if (desajuste) begin
                    err_count <= err_count + 5'd1;
                    if (err_count == 5'd0) begin
                        err_first_idx <= idx;
                    end
                end
                // idx stops at the last code so abcd keeps showing 15 in DONE
                if (idx != ULTIMO) begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    assign abcd = idx;

endmodule

// File: tb/tb_secuenciador_prueba_abcd.sv
module tb_secuenciador_prueba_abcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, start_a, start_b;
    logic [31:0] flip_a;

    logic [3:0] abcd_a, first_a, sidx_a, abcd_b, first_b, sidx_b;
    logic       f1_a, f2_a, busy_a, done_a, pass_a, sv_a, serr_a;
    logic       f1_b, f2_b, busy_b, done_b, pass_b, sv_b, serr_b;
    logic [4:0] errc_a, errc_b;
    logic [1:0] sf_a, sf_b;

    // Behavioural gate circuit: F1 low only for codes 0,5,7; F2 high for odd codes and 6
    function automatic logic [1:0] gates(input logic [3:0] c);
        logic g1, g2;
        g1 = !((c == 4'd0) || (c == 4'd5) || (c == 4'd7));
        g2 = c[0] || (c == 4'd6);
        return {g1, g2};
    endfunction

    assign {f1_a, f2_a} = gates(abcd_a) ^ flip_a[{abcd_a, 1'b0} +: 2];
    assign {f1_b, f2_b} = gates(abcd_b);

    secuenciador_prueba_abcd #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abcd(abcd_a), .f1(f1_a), .f2(f2_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(errc_a),
        .err_first_idx(first_a), .sample_valid(sv_a), .sample_idx(sidx_a),
        .sample_f(sf_a), .sample_err(serr_a));

    secuenciador_prueba_abcd #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abcd(abcd_b), .f1(f1_b), .f2(f2_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(errc_b),
        .err_first_idx(first_b), .sample_valid(sv_b), .sample_idx(sidx_b),
        .sample_f(sf_b), .sample_err(serr_b));

    bit         sel;
    logic       m_sv, m_done, m_busy, m_pass, m_serr;
    logic [3:0] m_sidx, m_abcd, m_first;
    logic [1:0] m_sf;
    logic [4:0] m_errc;
    assign m_sv    = sel ? sv_b    : sv_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_pass  = sel ? pass_b  : pass_a;
    assign m_serr  = sel ? serr_b  : serr_a;
    assign m_sidx  = sel ? sidx_b  : sidx_a;
    assign m_abcd  = sel ? abcd_b  : abcd_a;
    assign m_first = sel ? first_b : first_a;
    assign m_sf    = sel ? sf_b    : sf_a;
    assign m_errc  = sel ? errc_b  : errc_a;

    int n_cmp = 0;
    int n_fail = 0;

    // Captured sweep observations
    logic [3:0] q_idx[$];
    logic [1:0] q_f[$];
    logic       q_err[$];
    int         lat;
    logic       p_done, p_busy, p_pass;
    logic [3:0] p_abcd;
    logic [4:0] p_err;

    // Reference model results
    int         e_cnt, e_first;

    function automatic void model(input logic [31:0] flip);
        e_cnt = 0;
        e_first = -1;
        for (int i = 0; i < 16; i++) begin
            if (flip[2*i +: 2] != 2'b00) begin
                if (e_first < 0) e_first = i;
                e_cnt++;
            end
        end
    endfunction

    // Starts a sweep on the selected instance and records what it produces.
    // p1/p2 are cycle offsets after the start edge at which start is re-pulsed.
    task automatic sweep(input bit b, input int p1, input int p2);
        int t0;
        sel = b;
        q_idx.delete(); q_f.delete(); q_err.delete();
        lat = -1;
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        t0 = cyc;
        p_done = m_done; p_busy = m_busy; p_pass = m_pass; p_abcd = m_abcd; p_err = m_errc;
        for (int k = 0; k < 200; k++) begin
            if (m_sv) begin
                q_idx.push_back(m_sidx); q_f.push_back(m_sf); q_err.push_back(m_serr);
            end
            if (m_done) begin
                lat = cyc - t0;
                break;
            end
            if ((cyc - t0 == p1) || (cyc - t0 == p2)) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
            end
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; flip_a = '0;
        #1;
        n_cmp++; if ({abcd_a, busy_a, done_a, pass_a, errc_a, first_a, sv_a, sidx_a, sf_a, serr_a} !== '0) begin
            n_fail++; $display("FAIL reset_a outputs not zero: abcd=%0h busy=%0b done=%0b errc=%0d", abcd_a, busy_a, done_a, errc_a); end
        n_cmp++; if ({abcd_b, busy_b, done_b, pass_b, errc_b, first_b, sv_b, sidx_b, sf_b, serr_b} !== '0) begin
            n_fail++; $display("FAIL reset_b outputs not zero: abcd=%0h busy=%0b done=%0b", abcd_b, busy_b, done_b); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if ({busy_a, done_a} !== 2'b00) begin
            n_fail++; $display("FAIL idle busy/done got=%b exp=00", {busy_a, done_a}); end
    endtask

    task automatic test_golden();
        flip_a = '0;
        sweep(0, -1, -1);
        n_cmp++; if ({p_done, p_busy, p_abcd} !== {1'b0, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL golden_start done=%0b busy=%0b abcd=%0d exp 0 1 0", p_done, p_busy, p_abcd); end
        n_cmp++; if (lat !== 48) begin n_fail++; $display("FAIL golden_latency got=%0d exp=48", lat); end
        n_cmp++; if ({pass_a, errc_a} !== {1'b1, 5'd0}) begin
            n_fail++; $display("FAIL golden_pass pass=%0b errc=%0d exp 1 0", pass_a, errc_a); end
        n_cmp++; if (q_idx.size() !== 16) begin n_fail++; $display("FAIL golden_nsamples got=%0d exp=16", q_idx.size()); end
        for (int i = 0; i < 16 && i < q_idx.size(); i++) begin
            n_cmp++; if ({q_idx[i], q_f[i], q_err[i]} !== {4'(i), gates(4'(i)), 1'b0}) begin
                n_fail++; $display("FAIL golden_sample[%0d] idx=%0d f=%b err=%0b exp idx=%0d f=%b err=0", i, q_idx[i], q_f[i], q_err[i], i, gates(4'(i))); end
        end
    endtask

    task automatic test_fault_f2();
        flip_a = '0;
        for (int i = 0; i < 16; i++) flip_a[2*i] = gates(4'(i)) [0];
        model(flip_a);
        sweep(0, -1, -1);
        n_cmp++; if (errc_a !== 5'd9 || e_cnt != 9) begin n_fail++; $display("FAIL f2_errcount got=%0d exp=9", errc_a); end
        n_cmp++; if (first_a !== 4'd1) begin n_fail++; $display("FAIL f2_first got=%0d exp=1", first_a); end
        n_cmp++; if ({done_a, pass_a} !== 2'b10) begin n_fail++; $display("FAIL f2_pass done/pass got=%b exp=10", {done_a, pass_a}); end
        for (int i = 0; i < 16 && i < q_idx.size(); i++) begin
            n_cmp++; if ({q_idx[i], q_f[i], q_err[i]} !== {4'(i), gates(4'(i)) & 2'b10, gates(4'(i)) [0]}) begin
                n_fail++; $display("FAIL f2_sample[%0d] idx=%0d f=%b err=%0b", i, q_idx[i], q_f[i], q_err[i]); end
        end
    endtask

    task automatic test_mid_start();
        flip_a = $urandom & $urandom;
        model(flip_a);
        sweep(0, 5, 20);
        n_cmp++; if (lat !== 48) begin n_fail++; $display("FAIL midstart_latency got=%0d exp=48", lat); end
        n_cmp++; if (q_idx.size() !== 16) begin n_fail++; $display("FAIL midstart_nsamples got=%0d exp=16", q_idx.size()); end
        n_cmp++; if (errc_a !== 5'(e_cnt)) begin n_fail++; $display("FAIL midstart_errcount got=%0d exp=%0d", errc_a, e_cnt); end
        for (int i = 0; i < 16 && i < q_idx.size(); i++) begin
            n_cmp++; if ({q_idx[i], q_err[i]} !== {4'(i), flip_a[2*i +: 2] != 2'b00}) begin
                n_fail++; $display("FAIL midstart_sample[%0d] idx=%0d err=%0b", i, q_idx[i], q_err[i]); end
        end
    endtask

    task automatic test_start_at_last();
        flip_a = '0;
        sweep(0, 47, -1);
        n_cmp++; if (lat !== 48) begin n_fail++; $display("FAIL lastedge_latency got=%0d exp=48", lat); end
        n_cmp++; if (q_idx.size() !== 16) begin n_fail++; $display("FAIL lastedge_nsamples got=%0d exp=16", q_idx.size()); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({done_a, busy_a, abcd_a} !== {1'b1, 1'b0, 4'd15}) begin
            n_fail++; $display("FAIL lastedge_hold done=%0b busy=%0b abcd=%0d exp 1 0 15", done_a, busy_a, abcd_a); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        flip_a = 32'hFFFF_FFFF;
        sel = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (sv_a && sidx_a == 4'd7) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstmid_wait sample_idx 7 not seen within budget"); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({abcd_a, busy_a, done_a, pass_a, errc_a, first_a, sv_a, sidx_a, sf_a, serr_a} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs abcd=%0d busy=%0b errc=%0d sidx=%0d exp all 0", abcd_a, busy_a, errc_a, sidx_a); end
        @(negedge clk); rst_n = 1'b1;
        flip_a = $urandom;
        model(flip_a);
        sweep(0, -1, -1);
        n_cmp++; if ({p_abcd, p_err, p_busy} !== {4'd0, 5'd0, 1'b1}) begin
            n_fail++; $display("FAIL rstmid_restart abcd=%0d errc=%0d busy=%0b exp 0 0 1", p_abcd, p_err, p_busy); end
        n_cmp++; if (errc_a !== 5'(e_cnt)) begin n_fail++; $display("FAIL rstmid_errcount got=%0d exp=%0d", errc_a, e_cnt); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            case (r % 3)
                0: flip_a = $urandom & $urandom & $urandom;
                1: flip_a = $urandom;
                default: flip_a = $urandom | $urandom;
            endcase
            model(flip_a);
            sweep(0, -1, -1);
            n_cmp++; if (errc_a !== 5'(e_cnt)) begin n_fail++; $display("FAIL rand%0d_errcount got=%0d exp=%0d", r, errc_a, e_cnt); end
            n_cmp++; if (pass_a !== (e_cnt == 0)) begin n_fail++; $display("FAIL rand%0d_pass got=%0b exp=%0b", r, pass_a, e_cnt == 0); end
            if (e_cnt != 0) begin
                n_cmp++; if (first_a !== 4'(e_first)) begin n_fail++; $display("FAIL rand%0d_first got=%0d exp=%0d", r, first_a, e_first); end
            end
            for (int i = 0; i < 16 && i < q_idx.size(); i++) begin
                n_cmp++; if ({q_idx[i], q_f[i], q_err[i]} !== {4'(i), gates(4'(i)) ^ flip_a[2*i +: 2], flip_a[2*i +: 2] != 2'b00}) begin
                    n_fail++; $display("FAIL rand%0d_sample[%0d] idx=%0d f=%b err=%0b", r, i, q_idx[i], q_f[i], q_err[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] first_f[$];
        sweep(1, -1, -1);
        n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL s1_latency got=%0d exp=32", lat); end
        n_cmp++; if ({pass_b, errc_b} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL s1_pass pass=%0b errc=%0d", pass_b, errc_b); end
        first_f = q_f;
        sweep(1, -1, -1);
        n_cmp++; if ({p_done, p_pass, p_busy} !== 3'b001) begin
            n_fail++; $display("FAIL s1_restart done=%0b pass=%0b busy=%0b exp 0 0 1", p_done, p_pass, p_busy); end
        n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL s1_latency2 got=%0d exp=32", lat); end
        n_cmp++; if (q_idx.size() !== 16 || first_f.size() !== 16) begin
            n_fail++; $display("FAIL s1_nsamples got=%0d,%0d exp=16", first_f.size(), q_idx.size()); end
        for (int i = 0; i < 16 && i < q_idx.size() && i < first_f.size(); i++) begin
            n_cmp++; if ({q_idx[i], q_f[i], q_err[i]} !== {4'(i), first_f[i], 1'b0} || first_f[i] !== gates(4'(i))) begin
                n_fail++; $display("FAIL s1_repeat[%0d] idx=%0d f=%b/%b err=%0b exp f=%b", i, q_idx[i], first_f[i], q_f[i], q_err[i], gates(4'(i))); end
        end
        n_cmp++; if ({pass_b, errc_b} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL s1_pass2 pass=%0b errc=%0d", pass_b, errc_b); end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_fault_f2();
        test_mid_start();
        test_start_at_last();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
